hazard_fwd_ctrl: RTL and testbench

//  Combined hazard-detection and forwarding controller for the RV32I pipeline. Sits beside the ID/EX register.

---
 rtl/hazard_fwd_ctrl_if.sv | 38 +++
 rtl/hazard_fwd_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard/forwarding bundle between the decode stage and hazard_fwd_ctrl.
// master = decode side driving ID fields, slave = the controller.
interface hazard_fwd_ctrl_if #(
  parameter int unsigned REGADDR_WIDTH  = 5,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned CNT_WIDTH      = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic                     id_valid;
  logic [REGADDR_WIDTH-1:0] rs1_addr_id;
  logic [REGADDR_WIDTH-1:0] rs2_addr_id;
  logic                     rs1_used_id;
  logic                     rs2_used_id;
  logic [REGADDR_WIDTH-1:0] rd_addr_id;
  logic                     regs_write_id;
  logic                     mem_read_id;
  logic                     ext_stall;
  logic                     flush;
  logic                     perf_clr;
  logic                     stall_if_id;
  logic                     bubble_ex;
  logic [SEL_W-1:0]         forward_a;
  logic [SEL_W-1:0]         forward_b;
  logic [CNT_WIDTH-1:0]     perf_stall_cnt;

  modport master (
    output id_valid, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
           rd_addr_id, regs_write_id, mem_read_id, ext_stall, flush, perf_clr,
    input  stall_if_id, bubble_ex, forward_a, forward_b, perf_stall_cnt
  );

  modport slave (
    input  id_valid, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
           rd_addr_id, regs_write_id, mem_read_id, ext_stall, flush, perf_clr,
    output stall_if_id, bubble_ex, forward_a, forward_b, perf_stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Load-use hazard detection and registered forward-select generation for the RV32I pipeline.
// Tracks in-flight writers in a shift register aligned to EX, MEM, WB, ...
module hazard_fwd_ctrl #(
  parameter int unsigned REGADDR_WIDTH  = 5,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned LOAD_LATENCY   = 1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int unsigned N     = NUM_FWD_STAGES;
  localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic [N:1]               p_valid_q;
  logic [N:1]               p_wr_q;
  logic [N:1]               p_ld_q;
  logic [REGADDR_WIDTH-1:0] p_rd_q [1:N];

  logic [SEL_W-1:0]     fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]     fwd_b_q, fwd_b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [N:1]               live;
  logic [REGADDR_WIDTH-1:0] rs_addr [0:1];
  logic [1:0]               rs_used;
  logic [SEL_W-1:0]         sel [0:1];
  logic [1:0]               rs_hz;
  logic                     found;
  logic                     hazard;
  logic                     stall;
  logic                     bubble;

  always_comb begin
    rs_addr[0] = bus.rs1_addr_id;
    rs_addr[1] = bus.rs2_addr_id;
    rs_used    = {bus.rs2_used_id, bus.rs1_used_id};
    for (int unsigned k = 1; k <= N; k++) begin
      live[k] = p_valid_q[k] & p_wr_q[k] & (p_rd_q[k] != '0);
    end
    found = 1'b0;
    rs_hz = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      sel[s] = '0;
      found  = 1'b0;
      // Scan youngest first so a nearer writer masks an older load to the same rd.
      if (rs_used[s] && (rs_addr[s] != '0)) begin
        for (int unsigned k = 1; k <= N; k++) begin
          if (!found && live[k] && (p_rd_q[k] == rs_addr[s])) begin
            found     = 1'b1;
            sel[s]    = SEL_W'(k);
            rs_hz[s]  = p_ld_q[k] && (k <= LOAD_LATENCY);
          end
        end
      end
    end

    hazard = bus.id_valid & ~bus.flush & (|rs_hz);
    stall  = hazard & ~bus.ext_stall;
    bubble = (hazard | bus.flush) & ~bus.ext_stall;

    fwd_a_d = (bubble || !bus.id_valid) ? '0 : sel[0];
    fwd_b_d = (bubble || !bus.id_valid) ? '0 : sel[1];

    cnt_d = cnt_q;
    if (bus.perf_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= '0;
      p_wr_q    <= '0;
      p_ld_q    <= '0;
      for (int unsigned k = 1; k <= N; k++) begin
        p_rd_q[k] <= '0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else if (!bus.ext_stall) begin
      for (int unsigned k = N; k >= 2; k--) begin
        p_valid_q[k] <= p_valid_q[k-1];
        p_wr_q[k]    <= p_wr_q[k-1];
        p_ld_q[k]    <= p_ld_q[k-1];
        p_rd_q[k]    <= p_rd_q[k-1];
      end
      p_valid_q[1] <= bus.id_valid & ~bubble;
      p_wr_q[1]    <= bus.regs_write_id;
      p_ld_q[1]    <= bus.mem_read_id;
      p_rd_q[1]    <= bus.rd_addr_id;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.stall_if_id    = stall;
  assign bus.bubble_ex      = bubble;
  assign bus.forward_a      = fwd_a_q;
  assign bus.forward_b      = fwd_b_q;
  assign bus.perf_stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed table-driven bench for hazard_fwd_ctrl with default parameters.
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REGADDR_WIDTH(5), .NUM_FWD_STAGES(2), .CNT_WIDTH(16)) bus ();

  hazard_fwd_ctrl #(
    .REGADDR_WIDTH(5), .NUM_FWD_STAGES(2), .LOAD_LATENCY(1), .CNT_WIDTH(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, ext, fl, clr;
    logic       e_stall, e_bub;
    logic [1:0] e_fa, e_fb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2, input logic [4:0] rd,
    input logic wr, input logic ld, input logic ext, input logic fl, input logic clr,
    input logic e_stall, input logic e_bub, input logic [1:0] e_fa,
    input logic [1:0] e_fb, input logic [15:0] e_cnt);
    vec_t v;
    v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.wr = wr; v.ld = ld; v.ext = ext; v.fl = fl; v.clr = clr;
    v.e_stall = e_stall; v.e_bub = e_bub; v.e_fa = e_fa; v.e_fb = e_fb; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid      = v.idv;
    bus.rs1_addr_id   = v.rs1;
    bus.rs2_addr_id   = v.rs2;
    bus.rs1_used_id   = v.u1;
    bus.rs2_used_id   = v.u2;
    bus.rd_addr_id    = v.rd;
    bus.regs_write_id = v.wr;
    bus.mem_read_id   = v.ld;
    bus.ext_stall     = v.ext;
    bus.flush         = v.fl;
    bus.perf_clr      = v.clr;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d stall", idx), 32'(bus.stall_if_id), 32'(v.e_stall));
    chk($sformatf("v%0d bubble", idx), 32'(bus.bubble_ex), 32'(v.e_bub));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d fwd_a", idx), 32'(bus.forward_a), 32'(v.e_fa));
    chk($sformatf("v%0d fwd_b", idx), 32'(bus.forward_b), 32'(v.e_fb));
    chk($sformatf("v%0d cnt", idx), 32'(bus.perf_stall_cnt), 32'(v.e_cnt));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    drive(idle);
    rst_n = 1'b0;

    //        idv rs1 rs2 u1 u2 rd wr ld ext fl clr | st bub fa fb cnt
    // back-to-back ALU forward from MEM
    vecs.push_back(mk(1, 1, 2,1,1, 5,1,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1, 5, 1,1,1, 6,1,0,0,0,0, 0,0,1,0,0));
    // forward from WB across a nop
    vecs.push_back(mk(1, 0, 0,1,1, 5,1,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0, 0, 0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1, 2, 5,1,1, 7,1,0,0,0,0, 0,0,0,2,0));
    // load-use: one stall, then WB forward on both operands
    vecs.push_back(mk(1, 1, 0,1,0, 5,1,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1, 5, 5,1,1, 7,1,0,0,0,0, 1,1,0,0,1));
    vecs.push_back(mk(1, 5, 5,1,1, 7,1,0,0,0,0, 0,0,2,2,1));
    // x0 writers/loads are invisible
    vecs.push_back(mk(1, 1, 2,1,1, 0,1,0,0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(1, 0, 7,1,1, 8,1,0,0,0,0, 0,0,0,2,1));
    vecs.push_back(mk(1, 1, 0,1,0, 0,1,1,0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(1, 0, 8,1,1, 9,1,0,0,0,0, 0,0,0,2,1));
    // load-use under ext_stall freeze for 3 cycles
    vecs.push_back(mk(1, 9, 0,1,0,10,1,1,0,0,0, 0,0,1,0,1));
    vecs.push_back(mk(1,10, 0,1,0,11,1,0,1,0,0, 0,0,1,0,1));
    vecs.push_back(mk(1,10, 0,1,0,11,1,0,1,0,0, 0,0,1,0,1));
    vecs.push_back(mk(1,10, 0,1,0,11,1,0,1,0,0, 0,0,1,0,1));
    vecs.push_back(mk(1,10, 0,1,0,11,1,0,0,0,0, 1,1,0,0,2));
    vecs.push_back(mk(1,10, 0,1,0,11,1,0,0,0,0, 0,0,2,0,2));
    // hazard and flush together: flush wins
    vecs.push_back(mk(1, 0, 0,1,0,12,1,1,0,0,0, 0,0,0,0,2));
    vecs.push_back(mk(1,12,11,1,1,13,1,0,0,1,0, 0,1,0,0,2));
    // perf_clr, and perf_clr beating a stall increment
    vecs.push_back(mk(0, 0, 0,0,0, 0,0,0,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(1, 0, 0,1,0,14,1,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,14, 0,1,0,15,1,0,0,0,1, 1,1,0,0,0));
    vecs.push_back(mk(1,14, 0,1,0,15,1,0,0,0,0, 0,0,2,0,0));
    // x5 in WB and MEM: nearest (MEM) wins; unused rs never forwarded
    vecs.push_back(mk(1, 0, 0,1,1, 5,1,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1, 0, 0,1,1, 5,1,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1, 5, 5,1,1,16,1,0,0,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,16,16,0,1,17,1,0,0,0,0, 0,0,0,1,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst stall", 32'(bus.stall_if_id), 0);
    chk("rst bubble", 32'(bus.bubble_ex), 0);
    chk("rst fwd_a", 32'(bus.forward_a), 0);
    chk("rst fwd_b", 32'(bus.forward_b), 0);
    chk("rst cnt", 32'(bus.perf_stall_cnt), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // async reset in the middle of a load-use stall
    run_vec(mk(1, 0, 0,1,0,21,1,1,0,0,0, 0,0,0,0,0), 100);
    run_vec(mk(1,21, 0,1,0,22,1,0,0,0,0, 1,1,0,0,1), 101);
    run_vec(mk(1,21, 0,1,0,22,1,0,0,0,0, 0,0,2,0,1), 102);
    run_vec(mk(1,22, 0,1,0,23,1,1,0,0,0, 0,0,1,0,1), 103);
    @(negedge clk);
    drive(mk(1,23, 0,1,0,24,1,0,0,0,0, 0,0,0,0,0));
    #1;
    chk("pre-rst stall", 32'(bus.stall_if_id), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst stall", 32'(bus.stall_if_id), 0);
    chk("midrst bubble", 32'(bus.bubble_ex), 0);
    chk("midrst fwd_a", 32'(bus.forward_a), 0);
    chk("midrst fwd_b", 32'(bus.forward_b), 0);
    chk("midrst cnt", 32'(bus.perf_stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst stall", 32'(bus.stall_if_id), 0);
    @(posedge clk);
    #1;
    chk("postrst fwd_a", 32'(bus.forward_a), 0);
    chk("postrst cnt", 32'(bus.perf_stall_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
